// File: rtl/tt_rng_health_packer.sv
// rtl/tt_rng_health_packer.sv - TRNG health monitor (RCT/APT) and MSB-first byte packer with output FIFO
//
// Optional feature macro: TT_RNG_APT_EN (adaptive-proportion test; absent by default)
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous reset, active-high
//   enable     in   run request; low forces DISABLED
//   bit_in     in   raw random bit
//   bit_valid  in   bit_in accepted on each clk edge where high (WARMUP/RUN only)
//   clr_alarm  in   pulse: clears sticky flags, leaves ALARM
//   rnd_data   out  [7:0] FIFO head byte (0 when empty)
//   rnd_valid  out  FIFO non-empty and state RUN
//   rnd_ready  in   consumer pop strobe
//   state      out  [1:0] 00 DISABLED, 01 WARMUP, 10 RUN, 11 ALARM
//   rct_fail   out  sticky repetition-count failure
//   apt_fail   out  sticky adaptive-proportion failure
//   drop       out  sticky byte-dropped-on-full flag
module tt_rng_health_packer #(
  parameter int RCT_CUTOFF  = 16,
  parameter int APT_WINDOW  = 64,
  parameter int APT_CUTOFF  = 48,
  parameter int WARMUP_BITS = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       clr_alarm,
  output logic [7:0] rnd_data,
  output logic       rnd_valid,
  input  logic       rnd_ready,
  output logic [1:0] state,
  output logic       rct_fail,
  output logic       apt_fail,
  output logic       drop
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (RCT_CUTOFF < 2 || RCT_CUTOFF > 63 || APT_CUTOFF >= APT_WINDOW ||
      WARMUP_BITS < 1 || WARMUP_BITS > 255 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_bad_cfg
    $error("tt_rng_health_packer: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_WARMUP   = 2'b01,
    ST_RUN      = 2'b10,
    ST_ALARM    = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic          accept, health_fail, wu_done, flush;
  logic          rct_last, rct_hit, apt_hit;
  logic [5:0]    rct_cnt, rct_cnt_nx;
  logic [7:0]    wu_cnt;
  logic [6:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          byte_done, push, pop, full, drop_evt;
  logic [7:0]    wr_byte;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  assign state  = state_q;
  assign accept = bit_valid && enable && (state_q == ST_WARMUP || state_q == ST_RUN);

  // Run length after this bit; a zero count means "cleared", so the next bit starts a fresh run.
  always_comb begin
    rct_cnt_nx = 6'd1;
    if (rct_cnt != 6'd0 && bit_in == rct_last) rct_cnt_nx = rct_cnt + 6'd1;
  end
  assign rct_hit = accept && (rct_cnt_nx == 6'(RCT_CUTOFF));

`ifdef TT_RNG_APT_EN
  localparam int AW = $clog2(APT_WINDOW) + 1;
  logic          apt_ref, apt_ref_nx;
  logic [AW-1:0] apt_bits, apt_match, apt_bits_nx, apt_match_nx;

  // A window opens on the first bit after a clear or after APT_WINDOW bits have been seen.
  always_comb begin
    apt_ref_nx   = apt_ref;
    apt_bits_nx  = apt_bits + AW'(1);
    apt_match_nx = apt_match + AW'(bit_in == apt_ref);
    if (apt_bits == '0 || apt_bits == AW'(APT_WINDOW)) begin
      apt_ref_nx   = bit_in;
      apt_bits_nx  = AW'(1);
      apt_match_nx = AW'(1);
    end
  end
  assign apt_hit = accept && (apt_match_nx == AW'(APT_CUTOFF));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      apt_ref   <= 1'b0;
      apt_bits  <= '0;
      apt_match <= '0;
      apt_fail  <= 1'b0;
    end else begin
      if (clr_alarm) apt_fail <= 1'b0;
      if (apt_hit)   apt_fail <= 1'b1;
      if (flush) begin
        apt_ref   <= 1'b0;
        apt_bits  <= '0;
        apt_match <= '0;
      end else if (accept) begin
        apt_ref   <= apt_ref_nx;
        apt_bits  <= apt_bits_nx;
        apt_match <= apt_match_nx;
      end
    end
  end
`else
  assign apt_hit  = 1'b0;
  assign apt_fail = 1'b0;
`endif

  assign health_fail = rct_hit || apt_hit;
  assign wu_done     = accept && (state_q == ST_WARMUP) && (wu_cnt + 8'd1 == 8'(WARMUP_BITS));

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_WARMUP;
        ST_WARMUP: begin
          if (health_fail)  state_d = ST_ALARM;
          else if (wu_done) state_d = ST_RUN;
        end
        ST_RUN:   if (health_fail) state_d = ST_ALARM;
        ST_ALARM: if (clr_alarm)   state_d = ST_WARMUP;
        default:  state_d = ST_DISABLED;
      endcase
    end
  end

  // Every state entry except RUN starts from a clean slate.
  assign flush = (state_d != state_q) && (state_d != ST_RUN);

  // A failing bit never produces a byte, even if it is the 8th.
  assign byte_done = accept && (state_q == ST_RUN) && (bit_cnt == 3'd7) && !health_fail;
  assign wr_byte   = {shreg, bit_in};
  assign full      = (count == CW'(FIFO_DEPTH));
  assign rnd_valid = (count != '0) && (state_q == ST_RUN);
  assign rnd_data  = (count != '0) ? mem[rptr] : 8'h00;
  assign pop       = rnd_valid && rnd_ready;
  assign push      = byte_done && (!full || pop);
  assign drop_evt  = byte_done && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_byte;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= ST_DISABLED;
      rct_fail <= 1'b0;
      drop     <= 1'b0;
      rct_cnt  <= 6'd0;
      rct_last <= 1'b0;
      wu_cnt   <= 8'd0;
      shreg    <= 7'd0;
      bit_cnt  <= 3'd0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      state_q <= state_d;
      if (clr_alarm) begin
        rct_fail <= 1'b0;
        drop     <= 1'b0;
      end
      if (rct_hit)  rct_fail <= 1'b1;
      if (drop_evt) drop     <= 1'b1;
      if (flush) begin
        rct_cnt  <= 6'd0;
        rct_last <= 1'b0;
        wu_cnt   <= 8'd0;
        shreg    <= 7'd0;
        bit_cnt  <= 3'd0;
        wptr     <= '0;
        rptr     <= '0;
        count    <= '0;
      end else begin
        if (accept) begin
          rct_cnt  <= rct_cnt_nx;
          rct_last <= bit_in;
          if (state_q == ST_WARMUP) wu_cnt <= wu_cnt + 8'd1;
          if (state_q == ST_RUN) begin
            shreg   <= {shreg[5:0], bit_in};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_tt_rng_health_packer.sv
// tb/tb_tt_rng_health_packer.sv - directed self-checking bench for tt_rng_health_packer
module tb_tt_rng_health_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clr_alarm = 1'b0;
  logic       rnd_ready = 1'b0;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic [1:0] state;
  logic       rct_fail, apt_fail, drop;

  int nvec = 0;
  int nfail = 0;

  tt_rng_health_packer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .clr_alarm(clr_alarm), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .state(state), .rct_fail(rct_fail), .apt_fail(apt_fail), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic warmup_bits();
    for (int i = 0; i < 64; i++) send_bit(~i[0]);
  endtask

  task automatic restart();
    enable = 1'b0;
    clr_alarm = 1'b1;
    rnd_ready = 1'b0;
    tick();
    clr_alarm = 1'b0;
    enable = 1'b1;
    tick();
    warmup_bits();
  endtask

  task automatic test_reset();
    tick();
    tick();
    nvec++;
    if (state !== 2'b00 || rnd_valid !== 1'b0 || rnd_data !== 8'h00 ||
        rct_fail !== 1'b0 || apt_fail !== 1'b0 || drop !== 1'b0) begin
      nfail++;
      $display("FAIL reset: state=%b valid=%b data=%h rct=%b apt=%b drop=%b, need 00 0 00 0 0 0",
               state, rnd_valid, rnd_data, rct_fail, apt_fail, drop);
    end
    rst_n = 1'b0;
    tick();
    nvec++;
    if (state !== 2'b00) begin nfail++; $display("FAIL idle_disabled: state=%b need 00", state); end
  endtask

  task automatic test_warmup_run();
    enable = 1'b1;
    send_bit(1'b1);  // ignored in DISABLED
    nvec++;
    if (state !== 2'b01) begin nfail++; $display("FAIL enter_warmup: state=%b need 01", state); end
    for (int i = 0; i < 64; i++) begin
      send_bit(~i[0]);
      if (i == 62) begin
        nvec++;
        if (state !== 2'b01) begin nfail++; $display("FAIL warmup_63: state=%b need 01", state); end
      end
    end
    nvec++;
    if (state !== 2'b10) begin nfail++; $display("FAIL enter_run: state=%b need 10", state); end
    for (int i = 0; i < 7; i++) send_bit(~i[0]);
    nvec++;
    if (rnd_valid !== 1'b0) begin nfail++; $display("FAIL partial_byte: valid=%b need 0", rnd_valid); end
    send_bit(1'b0);
    nvec++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hAA) begin
      nfail++;
      $display("FAIL first_byte: valid=%b data=%h need 1 aa", rnd_valid, rnd_data);
    end
    tick();
    nvec++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hAA) begin
      nfail++;
      $display("FAIL hold_byte: valid=%b data=%h need 1 aa", rnd_valid, rnd_data);
    end
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
    nvec++;
    if (rnd_valid !== 1'b0) begin nfail++; $display("FAIL pop_empty: valid=%b need 0", rnd_valid); end
  endtask

  task automatic test_rct();
    for (int i = 1; i <= 16; i++) begin
      send_bit(1'b1);
      if (i == 15) begin
        nvec++;
        if (state !== 2'b10 || rct_fail !== 1'b0) begin
          nfail++;
          $display("FAIL rct_15: state=%b rct=%b need 10 0", state, rct_fail);
        end
      end
    end
    nvec++;
    if (state !== 2'b11 || rct_fail !== 1'b1 || rnd_valid !== 1'b0) begin
      nfail++;
      $display("FAIL rct_16: state=%b rct=%b valid=%b need 11 1 0", state, rct_fail, rnd_valid);
    end
    send_bit(1'b0);  // ignored in ALARM
    nvec++;
    if (state !== 2'b11 || rct_fail !== 1'b1) begin
      nfail++;
      $display("FAIL alarm_hold: state=%b rct=%b need 11 1", state, rct_fail);
    end
    clr_alarm = 1'b1;
    tick();
    clr_alarm = 1'b0;
    nvec++;
    if (state !== 2'b01 || rct_fail !== 1'b0) begin
      nfail++;
      $display("FAIL clr_alarm: state=%b rct=%b need 01 0", state, rct_fail);
    end
  endtask

  // Starts in WARMUP with counters freshly cleared; pattern 0001 x16 puts the 48th zero at bit 63.
  task automatic test_apt();
    logic [1:0] exp_st;
    logic       exp_apt;
    for (int i = 0; i < 63; i++) begin
      send_bit(i % 4 == 3);
      if (i == 61) begin
        nvec++;
        if (state !== 2'b01 || apt_fail !== 1'b0) begin
          nfail++;
          $display("FAIL apt_47: state=%b apt=%b need 01 0", state, apt_fail);
        end
      end
    end
`ifdef TT_RNG_APT_EN
    exp_st = 2'b11;
    exp_apt = 1'b1;
`else
    exp_st = 2'b01;
    exp_apt = 1'b0;
`endif
    nvec++;
    if (state !== exp_st || apt_fail !== exp_apt || rct_fail !== 1'b0) begin
      nfail++;
      $display("FAIL apt_48: state=%b apt=%b rct=%b need %b %b 0", state, apt_fail, rct_fail, exp_st, exp_apt);
    end
  endtask

  task automatic test_drop();
    logic [7:0] exp_b [5];
    exp_b = '{8'h35, 8'hC3, 8'h5A, 8'h96, 8'h69};
    restart();
    for (int i = 0; i < 4; i++) send_byte(exp_b[i]);
    nvec++;
    if (drop !== 1'b0 || rnd_data !== 8'h35) begin
      nfail++;
      $display("FAIL fill_4: drop=%b data=%h need 0 35", drop, rnd_data);
    end
    send_byte(exp_b[4]);
    nvec++;
    if (drop !== 1'b1 || rnd_valid !== 1'b1 || rnd_data !== 8'h35) begin
      nfail++;
      $display("FAIL drop_5th: drop=%b valid=%b data=%h need 1 1 35", drop, rnd_valid, rnd_data);
    end
    rnd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (rnd_valid !== 1'b1 || rnd_data !== exp_b[i]) begin
        nfail++;
        $display("FAIL drain_%0d: valid=%b data=%h need 1 %h", i, rnd_valid, rnd_data, exp_b[i]);
      end
      tick();
    end
    rnd_ready = 1'b0;
    nvec++;
    if (rnd_valid !== 1'b0 || drop !== 1'b1) begin
      nfail++;
      $display("FAIL drained: valid=%b drop=%b need 0 1", rnd_valid, drop);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] b [5];
    b = '{8'hA5, 8'h3C, 8'h66, 8'h99, 8'h5A};
    restart();
    for (int i = 0; i < 4; i++) send_byte(b[i]);
    for (int i = 7; i >= 1; i--) send_bit(b[4][i]);
    rnd_ready = 1'b1;
    send_bit(b[4][0]);
    nvec++;
    if (drop !== 1'b0 || rnd_data !== 8'h3C) begin
      nfail++;
      $display("FAIL pop_write: drop=%b data=%h need 0 3c", drop, rnd_data);
    end
    for (int i = 1; i < 5; i++) begin
      nvec++;
      if (rnd_valid !== 1'b1 || rnd_data !== b[i]) begin
        nfail++;
        $display("FAIL order_%0d: valid=%b data=%h need 1 %h", i, rnd_valid, rnd_data, b[i]);
      end
      tick();
    end
    rnd_ready = 1'b0;
    nvec++;
    if (rnd_valid !== 1'b0) begin nfail++; $display("FAIL four_only: valid=%b need 0", rnd_valid); end
  endtask

  task automatic test_disable();
    restart();
    send_byte(8'h6C);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    enable = 1'b0;
    tick();
    nvec++;
    if (state !== 2'b00 || rnd_valid !== 1'b0 || rnd_data !== 8'h00) begin
      nfail++;
      $display("FAIL disable: state=%b valid=%b data=%h need 00 0 00", state, rnd_valid, rnd_data);
    end
    enable = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      send_bit(~i[0]);
      if (i == 62) begin
        nvec++;
        if (state !== 2'b01) begin nfail++; $display("FAIL rewarm_63: state=%b need 01", state); end
      end
    end
    nvec++;
    if (state !== 2'b10) begin nfail++; $display("FAIL rewarm_64: state=%b need 10", state); end
    send_byte(8'h3A);
    nvec++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'h3A) begin
      nfail++;
      $display("FAIL fresh_byte: valid=%b data=%h need 1 3a", rnd_valid, rnd_data);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    send_byte(8'h96);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b1;
    #1;
    nvec++;
    if (state !== 2'b00 || rnd_valid !== 1'b0 || rnd_data !== 8'h00) begin
      nfail++;
      $display("FAIL async_reset: state=%b valid=%b data=%h need 00 0 00", state, rnd_valid, rnd_data);
    end
    tick();
    rst_n = 1'b0;
    tick();
    warmup_bits();
    nvec++;
    if (state !== 2'b10) begin nfail++; $display("FAIL reset_rewarm: state=%b need 10", state); end
    send_byte(8'hC5);
    nvec++;
    if (rnd_valid !== 1'b1 || rnd_data !== 8'hC5) begin
      nfail++;
      $display("FAIL reset_byte: valid=%b data=%h need 1 c5", rnd_valid, rnd_data);
    end
  endtask

  initial begin
    test_reset();
    test_warmup_run();
    test_rct();
    test_apt();
    test_drop();
    test_full_pop();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/tt_rng_health_packer.md
TT_RNG_HEALTH_PACKER -- requirements
Module: tt_rng_health_packer

Interface
REQ-001 SHALL have parameter: RCT_CUTOFF, 16, repetition-count fail threshold in consecutive identical bits (range 2..63).
REQ-002 SHALL have parameter: APT_WINDOW, 64, adaptive-proportion window length in bits (power of two, 16..256).
REQ-003 SHALL have parameter: APT_CUTOFF, 48, APT fail threshold in matching bits per window (less than APT_WINDOW).
REQ-004 SHALL have parameter: WARMUP_BITS, 64, number of accepted bits discarded after start (1..255).
REQ-005 SHALL have parameter: FIFO_DEPTH, 4, output byte FIFO entries (power of two, 2..16).
REQ-006 SHALL use clock clk and reset rst_n; the reset is asynchronous and active-high.
REQ-007 SHALL have port: clk  in  1  clock.
REQ-008 SHALL have port: rst_n  in  1  asynchronous reset, active-high.
REQ-009 SHALL have port: enable  in  1  run request; low forces DISABLED.
REQ-010 SHALL have port: bit_in  in  1  raw random bit (XOR-combined TRNG bitstream).
REQ-011 SHALL have port: bit_valid  in  1  bit_in is accepted on each clk edge where this is high.
REQ-012 SHALL have port: clr_alarm  in  1  one-cycle pulse; clears sticky flags and leaves ALARM.
REQ-013 SHALL have port: rnd_data  out  8  FIFO head byte.
REQ-014 SHALL have port: rnd_valid  out  1  FIFO non-empty and state RUN.
REQ-015 SHALL have port: rnd_ready  in  1  consumer pop; a pop occurs when rnd_valid and rnd_ready are both high.
REQ-016 SHALL have port: state  out  2  00 DISABLED, 01 WARMUP, 10 RUN, 11 ALARM.
REQ-017 SHALL have port: rct_fail, apt_fail, drop  out  1 each  sticky flags.

Function
REQ-018 SHALL implement FSM: DISABLED->WARMUP when enable; WARMUP->RUN after WARMUP_BITS accepted bits; WARMUP/RUN->ALARM on any health failure; any state->DISABLED when enable low (enable low has priority over all other transitions).
REQ-019 SHALL leave ALARM only on clr_alarm: go to WARMUP if enable is high, otherwise to DISABLED.
REQ-020 SHALL, on every entry to WARMUP or ALARM or DISABLED, flush the FIFO, discard the partial byte, and clear the RCT and APT counters.
REQ-021 SHALL run RCT in WARMUP and RUN: the first bit after a clear starts a run of length 1; an identical bit increments the run; a differing bit restarts it at 1; reaching RCT_CUTOFF sets rct_fail and enters ALARM at that same edge.
REQ-022 SHALL run APT (when compiled in): the first bit of each window is the reference and counts as 1 match; reaching APT_CUTOFF matches within the window sets apt_fail and enters ALARM; after APT_WINDOW bits the next bit starts a new window.
REQ-023 SHALL, in RUN only, shift accepted bits MSB-first: the first bit of a byte lands in rnd_data bit 7.
REQ-024 SHALL write the completed byte into the FIFO at the edge that accepts its 8th bit, so rnd_valid is high in the following cycle.
REQ-025 SHALL, when the FIFO is full and no pop occurs at that edge, drop the byte and set drop; if a pop occurs at the same edge, the write SHALL succeed.
REQ-026 SHALL ignore bit_valid in DISABLED and ALARM.
REQ-027 SHALL, when a failing bit also completes a byte, discard that byte (ALARM wins).
REQ-028 SHALL hold rnd_data stable while rnd_valid is high and no pop occurs.
REQ-029 SHALL clear rct_fail, apt_fail, and drop on clr_alarm, and SHALL NOT clear them otherwise (except by reset).

Reset
REQ-030 SHALL, while rst_n is high, force: state=DISABLED, FIFO empty, rnd_valid=0, rnd_data=0, all flags=0, all counters=0.
REQ-031 SHALL, when reset asserts mid-byte or mid-window, discard all progress; operation restarts with a full warmup.

Configuration
REQ-032 SHALL support macro TT_RNG_APT_EN: when defined, APT logic per REQ-022 is present; when undefined, APT is absent, apt_fail is tied to 0, and only RCT can cause ALARM.

Verification
REQ-033 SHALL cover: reset, enable=1, alternating 1010... bits with bit_valid=1 every cycle -> state goes 01 then 10 after 64 bits; after 8 more bits, rnd_data=8'hAA and rnd_valid=1 the next cycle.
REQ-034 SHALL cover: RUN with 16 consecutive 1s -> rct_fail=1 and state=11 at the 16th bit; rnd_valid=0; clr_alarm -> state=01.
REQ-035 SHALL cover (TT_RNG_APT_EN defined): window of 48 zeros interleaved with 16 ones (no run reaching 16) -> apt_fail=1 at the 48th zero; same stimulus with the macro undefined -> no alarm.
REQ-036 SHALL cover: rnd_ready=0, 5 bytes produced -> 4 bytes held, drop=1; then pop 4 -> bytes delivered in order, rnd_valid=0.
REQ-037 SHALL cover: FIFO full, pop at the same edge as the 8th bit -> no drop, FIFO stays at 4 entries.
REQ-038 SHALL cover: enable deasserted mid-byte in RUN -> state=00 the next cycle, FIFO empty, re-enable -> full 64-bit warmup repeated.
